// File: rtl/id_pipe.sv
// ---------------------------------------------------------------------------
// id_pipe : registered instruction-decode stage of the in-order MIPS pipeline
//
// Sits between IF/ID and EX. Decodes the logic / shift / immediate subset,
// reads the register file combinationally, forwards EX and MEM results,
// detects load-use hazards and holds or flushes its output register under a
// valid/ready handshake.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_valid_i / if_ready_o  upstream handshake (pc_i, inst_i)
//   reg{1,2}_read_o/addr_o   register file read request (combinational)
//   reg{1,2}_data_i          register file read data
//   ex_* / mem_*             result bypass from EX and MEM
//   flush_i                  kill the stage contents
//   ex_ready_i / id_valid_o  downstream handshake
//   aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o
//                            registered decode results
//
// Build option
//   ID_STALL_CNT_EN : adds stall_cnt_o[31:0], a saturating count of the
//                     load-use bubbles inserted into the pipeline.
// ---------------------------------------------------------------------------
module id_pipe #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [PC_W-1:0]     pc_i,
  input  logic [31:0]         inst_i,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush_i,
  input  logic                ex_ready_i,
  output logic                id_valid_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic [PC_W-1:0]     pc_o,
  output logic                inst_invalid_o
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  // Shared EXE encodings used by the EX stage.
  localparam logic [ALUOP_W-1:0]  EXE_NOP_OP    = ALUOP_W'(8'b0000_0000);
  localparam logic [ALUOP_W-1:0]  EXE_AND_OP    = ALUOP_W'(8'b0010_0100);
  localparam logic [ALUOP_W-1:0]  EXE_OR_OP     = ALUOP_W'(8'b0010_0101);
  localparam logic [ALUOP_W-1:0]  EXE_XOR_OP    = ALUOP_W'(8'b0010_0110);
  localparam logic [ALUOP_W-1:0]  EXE_NOR_OP    = ALUOP_W'(8'b0010_0111);
  localparam logic [ALUOP_W-1:0]  EXE_SLL_OP    = ALUOP_W'(8'b0111_1100);
  localparam logic [ALUOP_W-1:0]  EXE_SRL_OP    = ALUOP_W'(8'b0000_0010);
  localparam logic [ALUOP_W-1:0]  EXE_SRA_OP    = ALUOP_W'(8'b0000_0011);
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = ALUSEL_W'(3'b000);
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = ALUSEL_W'(3'b010);

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'b000000,
    OP_ANDI    = 6'b001100,
    OP_ORI     = 6'b001101,
    OP_XORI    = 6'b001110,
    OP_LUI     = 6'b001111
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'b000000,
    FN_SRL = 6'b000010,
    FN_SRA = 6'b000011,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_XOR = 6'b100110,
    FN_NOR = 6'b100111
  } funct_e;

  // Instruction fields
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [4:0]        shamt;
  logic [15:0]       imm16;

  assign opcode  = inst_i[31:26];
  assign rs_addr = REG_AW'(inst_i[25:21]);
  assign rt_addr = REG_AW'(inst_i[20:16]);
  assign rd_addr = REG_AW'(inst_i[15:11]);
  assign shamt   = inst_i[10:6];
  assign funct   = inst_i[5:0];
  assign imm16   = inst_i[15:0];

  // Decode results
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic                dec_wreg;
  logic [REG_AW-1:0]   dec_wd;
  logic                dec_read1;
  logic                dec_read2;
  logic                dec_shift;    // op1 comes from rt (port 2)
  logic [DATA_W-1:0]   dec_imm;
  logic                dec_invalid;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the case statements can leave it unassigned (no latch).
  always_comb begin
    dec_aluop   = EXE_NOP_OP;
    dec_alusel  = EXE_RES_NOP;
    dec_wreg    = 1'b0;
    dec_wd      = '0;
    dec_read1   = 1'b0;
    dec_read2   = 1'b0;
    dec_shift   = 1'b0;
    dec_imm     = '0;
    dec_invalid = 1'b0;

    unique case (opcode)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_alusel = EXE_RES_LOGIC;
        dec_wreg   = 1'b1;
        dec_wd     = rt_addr;
        dec_read1  = 1'b1;
        dec_imm    = DATA_W'(imm16);
        dec_aluop  = (opcode == OP_ORI)  ? EXE_OR_OP  :
                     (opcode == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
      end
      OP_LUI: begin
        dec_aluop  = EXE_OR_OP;
        dec_alusel = EXE_RES_LOGIC;
        dec_wreg   = 1'b1;
        dec_wd     = rt_addr;
        dec_imm    = DATA_W'({imm16, 16'h0000});
      end
      OP_SPECIAL: begin
        unique case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            dec_alusel = EXE_RES_LOGIC;
            dec_wreg   = 1'b1;
            dec_wd     = rd_addr;
            dec_read1  = 1'b1;
            dec_read2  = 1'b1;
            dec_aluop  = (funct == FN_AND) ? EXE_AND_OP :
                         (funct == FN_OR)  ? EXE_OR_OP  :
                         (funct == FN_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // The all-zero word (sll $0,$0,0) is the canonical NOP: it keeps
            // the defaults and must not read, stall or write.
            if (inst_i != 32'h0000_0000) begin
              dec_alusel = EXE_RES_SHIFT;
              dec_wreg   = 1'b1;
              dec_wd     = rd_addr;
              dec_read2  = 1'b1;
              dec_shift  = 1'b1;
              dec_imm    = DATA_W'(shamt);
              dec_aluop  = (funct == FN_SLL) ? EXE_SLL_OP :
                           (funct == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
            end
          end
          default: dec_invalid = 1'b1;
        endcase
      end
      default: dec_invalid = 1'b1;
    endcase
  end

  // Register file request; held quiet while in reset.
  assign reg1_read_o = rst ? 1'b0 : dec_read1;
  assign reg2_read_o = rst ? 1'b0 : dec_read2;
  assign reg1_addr_o = rst ? '0 : rs_addr;
  assign reg2_addr_o = rst ? '0 : rt_addr;

  // Bypass priority: $0 -> EX (loads excluded, data not ready) -> MEM -> RF.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_wreg,
    input logic [REG_AW-1:0] ex_wd,
    input logic              ex_is_load,
    input logic [DATA_W-1:0] ex_wdata,
    input logic              mem_wreg,
    input logic [REG_AW-1:0] mem_wd,
    input logic [DATA_W-1:0] mem_wdata
  );
    if (addr == '0)                                return '0;
    else if (ex_wreg && ex_wd == addr && !ex_is_load) return ex_wdata;
    else if (mem_wreg && mem_wd == addr)           return mem_wdata;
    else                                           return rf_data;
  endfunction

  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;
  logic [DATA_W-1:0] op1_d;
  logic [DATA_W-1:0] op2_d;

  assign fwd1 = fwd_sel(rs_addr, reg1_data_i, ex_wreg_i, ex_wd_i, ex_is_load_i,
                        ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign fwd2 = fwd_sel(rt_addr, reg2_data_i, ex_wreg_i, ex_wd_i, ex_is_load_i,
                        ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);

  // Shifts put rt in op1 and the shift amount in op2.
  assign op1_d = dec_shift ? fwd2 : (dec_read1 ? fwd1 : '0);
  assign op2_d = (dec_read2 && !dec_shift) ? fwd2 : dec_imm;

  // Load-use hazard: the loaded value only exists after MEM, so wait.
  logic stall;
  logic advance;

  assign stall = if_valid_i && ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                 ((dec_read1 && ex_wd_i == rs_addr) ||
                  (dec_read2 && ex_wd_i == rt_addr));

  assign advance    = !id_valid_o || ex_ready_i;
  assign if_ready_o = advance && !stall && !flush_i;

  // Output register
  logic                valid_q;
  logic [ALUOP_W-1:0]  aluop_q;
  logic [ALUSEL_W-1:0] alusel_q;
  logic [DATA_W-1:0]   reg1_q;
  logic [DATA_W-1:0]   reg2_q;
  logic [REG_AW-1:0]   wd_q;
  logic                wreg_q;
  logic [PC_W-1:0]     pc_q;
  logic                invalid_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      aluop_q   <= '0;
      alusel_q  <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      pc_q      <= '0;
      invalid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
    end else if (advance) begin
      // A stall still advances, but with valid cleared: a bubble.
      valid_q   <= if_valid_i && !stall;
      aluop_q   <= dec_aluop;
      alusel_q  <= dec_alusel;
      reg1_q    <= op1_d;
      reg2_q    <= op2_d;
      wd_q      <= dec_wd;
      wreg_q    <= dec_wreg;
      pc_q      <= pc_i;
      invalid_q <= dec_invalid;
    end
  end

  assign id_valid_o     = valid_q;
  assign aluop_o        = aluop_q;
  assign alusel_o       = alusel_q;
  assign reg1_o         = reg1_q;
  assign reg2_o         = reg2_q;
  assign wd_o           = wd_q;
  assign wreg_o         = wreg_q;
  assign pc_o           = pc_q;
  assign inst_invalid_o = invalid_q;

`ifdef ID_STALL_CNT_EN
  // Counts bubbles actually inserted (edges where the stage advanced).
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && advance && !flush_i && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_pipe : self-checking bench for id_pipe
//
// Table of directed decode/forwarding vectors applied back to back, followed
// by hand-written sequences for load-use stall, hold, flush and async reset.
// ---------------------------------------------------------------------------
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        ex_is_load_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        flush_i;
  logic        ex_ready_i;
  logic        id_valid_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] pc_o;
  logic        inst_invalid_o;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  id_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid_i     (if_valid_i),
    .if_ready_o     (if_ready_o),
    .pc_i           (pc_i),
    .inst_i         (inst_i),
    .reg1_read_o    (reg1_read_o),
    .reg2_read_o    (reg2_read_o),
    .reg1_addr_o    (reg1_addr_o),
    .reg2_addr_o    (reg2_addr_o),
    .reg1_data_i    (reg1_data_i),
    .reg2_data_i    (reg2_data_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_wdata_i     (ex_wdata_i),
    .ex_is_load_i   (ex_is_load_i),
    .mem_wreg_i     (mem_wreg_i),
    .mem_wd_i       (mem_wd_i),
    .mem_wdata_i    (mem_wdata_i),
    .flush_i        (flush_i),
    .ex_ready_i     (ex_ready_i),
    .id_valid_o     (id_valid_o),
    .aluop_o        (aluop_o),
    .alusel_o       (alusel_o),
    .reg1_o         (reg1_o),
    .reg2_o         (reg2_o),
    .wd_o           (wd_o),
    .wreg_o         (wreg_o),
    .pc_o           (pc_o),
    .inst_invalid_o (inst_invalid_o)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  localparam logic [7:0] NOP = 8'h00, AND = 8'h24, OR = 8'h25, XOR = 8'h26,
                         NOR = 8'h27, SLL = 8'h7C, SRL = 8'h02, SRA = 8'h03;
  localparam logic [2:0] R_NOP = 3'd0, R_LOG = 3'd1, R_SHF = 3'd2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] r1d, r2d;
    logic        ex_wreg;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        e_rd1, e_rd2;
    logic [31:0] e_reg1, e_reg2;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [7:0]  e_aluop;
    logic [2:0]  e_alusel;
    logic        e_inv;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vec [NVEC];

  task automatic idle_inputs();
    if_valid_i   = 1'b1;
    ex_ready_i   = 1'b1;
    flush_i      = 1'b0;
    ex_is_load_i = 1'b0;
    ex_wreg_i    = 1'b0;
    ex_wd_i      = '0;
    ex_wdata_i   = '0;
    mem_wreg_i   = 1'b0;
    mem_wd_i     = '0;
    mem_wdata_i  = '0;
    reg1_data_i  = '0;
    reg2_data_i  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            inst          r1d           r2d         exw exwd exdata       mw  mwd mdata        rd1 rd2 reg1          reg2          wd  wr  aluop alusel inv
    vec[0]  = '{32'h34011234, 32'h0,        32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 32'h0,        32'h00001234, 1,  1, OR,  R_LOG, 0}; // ori $1,$0
    vec[1]  = '{32'h00221825, 32'h1,        32'h2,        1, 1,  32'hAAAA0000, 1, 2,  32'h00000F0F, 1, 1, 32'hAAAA0000, 32'h00000F0F, 3,  1, OR,  R_LOG, 0}; // or, EX/MEM fwd
    vec[2]  = '{32'h30858001, 32'hFFFF00FF, 32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 32'hFFFF00FF, 32'h00008001, 5,  1, AND, R_LOG, 0}; // andi zero-ext
    vec[3]  = '{32'h38C7FFFF, 32'h0000CAFE, 32'h0,        0, 0,  32'h0,        1, 6,  32'h12345678, 1, 0, 32'h12345678, 32'h0000FFFF, 7,  1, XOR, R_LOG, 0}; // xori, MEM fwd
    vec[4]  = '{32'h3C08ABCD, 32'h77777777, 32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 32'h0,        32'hABCD0000, 8,  1, OR,  R_LOG, 0}; // lui
    vec[5]  = '{32'h014B4827, 32'h0F0F0F0F, 32'h00FF00FF, 0, 0,  32'h0,        0, 0,  32'h0,        1, 1, 32'h0F0F0F0F, 32'h00FF00FF, 9,  1, NOR, R_LOG, 0}; // nor
    vec[6]  = '{32'h00031100, 32'h0,        32'h00000011, 0, 0,  32'h0,        0, 0,  32'h0,        0, 1, 32'h00000011, 32'h00000004, 2,  1, SLL, R_SHF, 0}; // sll
    vec[7]  = '{32'h000527C3, 32'h0,        32'h00000007, 1, 5,  32'h80000000, 0, 0,  32'h0,        0, 1, 32'h80000000, 32'h0000001F, 4,  1, SRA, R_SHF, 0}; // sra, EX fwd
    vec[8]  = '{32'h00003042, 32'h0,        32'hDEADBEEF, 1, 0,  32'h00000055, 1, 0,  32'h66,       0, 1, 32'h0,        32'h00000001, 6,  1, SRL, R_SHF, 0}; // srl $0 -> 0
    vec[9]  = '{32'h00000000, 32'h12,       32'h34,       0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 32'h0,        32'h0,        0,  0, NOP, R_NOP, 0}; // nop
    vec[10] = '{32'hFC000000, 32'h12,       32'h34,       0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 32'h0,        32'h0,        0,  0, NOP, R_NOP, 1}; // reserved
    vec[11] = '{32'h00430824, 32'h11111111, 32'h22222222, 0, 2,  32'h99999999, 0, 3,  32'h88888888, 1, 1, 32'h11111111, 32'h22222222, 1,  1, AND, R_LOG, 0}; // and, no wreg

    // ---- reset ----
    idle_inputs();
    rst    = 1'b1;
    pc_i   = 32'h0000_0FFC;
    inst_i = 32'h00221825;
    #2;
    check("rst.reg1_read", reg1_read_o, 0);
    check("rst.reg2_read", reg2_read_o, 0);
    check("rst.reg1_addr", reg1_addr_o, 0);
    check("rst.reg2_addr", reg2_addr_o, 0);
    tick();
    tick();
    rst = 1'b0;
    check("rst.id_valid", id_valid_o, 0);
    check("rst.wreg", wreg_o, 0);
    check("rst.reg2", reg2_o, 0);
    check("rst.pc", pc_o, 0);
`ifdef ID_STALL_CNT_EN
    check("rst.stall_cnt", stall_cnt_o, 0);
`endif

    // ---- decode / forwarding table, one instruction per cycle ----
    for (int i = 0; i < NVEC; i++) begin
      logic [31:0] exp_pc;
      exp_pc       = 32'h1000 + 32'(i * 4);
      inst_i       = vec[i].inst;
      pc_i         = exp_pc;
      reg1_data_i  = vec[i].r1d;
      reg2_data_i  = vec[i].r2d;
      ex_wreg_i    = vec[i].ex_wreg;
      ex_wd_i      = vec[i].ex_wd;
      ex_wdata_i   = vec[i].ex_wdata;
      mem_wreg_i   = vec[i].mem_wreg;
      mem_wd_i     = vec[i].mem_wd;
      mem_wdata_i  = vec[i].mem_wdata;
      #1;
      check($sformatf("v%0d.if_ready", i), if_ready_o, 1);
      check($sformatf("v%0d.reg1_read", i), reg1_read_o, vec[i].e_rd1);
      check($sformatf("v%0d.reg2_read", i), reg2_read_o, vec[i].e_rd2);
      check($sformatf("v%0d.reg1_addr", i), reg1_addr_o, vec[i].inst[25:21]);
      tick();
      check($sformatf("v%0d.id_valid", i), id_valid_o, 1);
      check($sformatf("v%0d.reg1", i), reg1_o, vec[i].e_reg1);
      check($sformatf("v%0d.reg2", i), reg2_o, vec[i].e_reg2);
      check($sformatf("v%0d.wd", i), wd_o, vec[i].e_wd);
      check($sformatf("v%0d.wreg", i), wreg_o, vec[i].e_wreg);
      check($sformatf("v%0d.aluop", i), aluop_o, vec[i].e_aluop);
      check($sformatf("v%0d.alusel", i), alusel_o, vec[i].e_alusel);
      check($sformatf("v%0d.invalid", i), inst_invalid_o, vec[i].e_inv);
      check($sformatf("v%0d.pc", i), pc_o, exp_pc);
    end

    // ---- load-use stall on rt ----
    idle_inputs();
    inst_i       = 32'h00221825;   // or $3,$1,$2
    pc_i         = 32'h0000_1800;
    reg1_data_i  = 32'h10;
    reg2_data_i  = 32'h20;
    ex_is_load_i = 1'b1;
    ex_wreg_i    = 1'b1;
    ex_wd_i      = 5'd2;
    ex_wdata_i   = 32'h999;
    #1;
    check("stall.if_ready", if_ready_o, 0);
    tick();
    check("stall.bubble", id_valid_o, 0);
    ex_is_load_i = 1'b0;
    ex_wreg_i    = 1'b0;
    #1;
    check("stall.release_ready", if_ready_o, 1);
    tick();
    check("stall.accept_valid", id_valid_o, 1);
    check("stall.accept_reg1", reg1_o, 32'h10);
    check("stall.accept_reg2", reg2_o, 32'h20);
    check("stall.accept_wd", wd_o, 3);
`ifdef ID_STALL_CNT_EN
    check("stall.cnt", stall_cnt_o, 1);
`endif

    // ---- hold while EX is busy, then flush ----
    idle_inputs();
    inst_i = 32'h34011234;         // ori $1,$0,0x1234
    pc_i   = 32'h0000_2000;
    tick();
    check("hold.load_valid", id_valid_o, 1);
    ex_ready_i  = 1'b0;
    inst_i      = 32'h30858001;    // different word waiting upstream
    pc_i        = 32'h0000_3000;
    reg1_data_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("hold%0d.if_ready", k), if_ready_o, 0);
      tick();
      check($sformatf("hold%0d.valid", k), id_valid_o, 1);
      check($sformatf("hold%0d.reg2", k), reg2_o, 32'h00001234);
      check($sformatf("hold%0d.wd", k), wd_o, 1);
      check($sformatf("hold%0d.pc", k), pc_o, 32'h0000_2000);
      check($sformatf("hold%0d.aluop", k), aluop_o, OR);
    end
    flush_i = 1'b1;
    #1;
    check("flush.if_ready", if_ready_o, 0);
    tick();
    check("flush.valid", id_valid_o, 0);
    check("flush.wreg", wreg_o, 0);
    flush_i = 1'b0;

    // ---- async reset in the middle of a hold ----
    ex_ready_i = 1'b1;
    inst_i     = 32'h34011234;
    pc_i       = 32'h0000_4000;
    tick();
    check("arst.pre_valid", id_valid_o, 1);
    ex_ready_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", id_valid_o, 0);
    check("arst.wreg", wreg_o, 0);
    check("arst.reg2", reg2_o, 0);
    check("arst.wd", wd_o, 0);
    check("arst.pc", pc_o, 0);
    check("arst.aluop", aluop_o, 0);
    check("arst.reg1_read", reg1_read_o, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
